// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the streaming radix-2 FFT:
//   - FSM state encodings (IDLE, LOAD, COMPUTE, UNLOAD)
//   - bitrev()   : reverse the low 'bits' bits of an index
//   - tw_quant() : elaboration-time twiddle quantiser, W = exp(-j*2*pi*k/N)
//                  scaled to signed Q2.(tw_width-2), rounded to nearest
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_UNLOAD  = 2'd3;

    localparam real PI = 3.14159265358979323846;

    function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < bits; i++) begin
            r = (r << 1) | ((v >> i) & 32'd1);
        end
        return r;
    endfunction

    // Real or imaginary part of exp(-j*2*pi*k/2**log2n) in Q2.(tw_width-2).
    function automatic int tw_quant(input int unsigned k, input int unsigned log2n,
                                    input int unsigned tw_width, input bit want_imag);
        real ang;
        real scale;
        real v;
        ang   = -2.0 * PI * real'(k) / real'(longint'(1) << log2n);
        scale = real'(longint'(1) << (tw_width - 2));
        v     = (want_imag ? $sin(ang) : $cos(ang)) * scale;
        if (v >= 0.0) begin
            return $rtoi(v + 0.5);
        end
        return -$rtoi(-v + 0.5);
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// ---------------------------------------------------------------------------
// fft_twiddle_rom
// Constant twiddle table for an N = 2**LOG2N point DIT FFT. Holds the N/2
// factors W^k = exp(-j*2*pi*k/N), k = 0..N/2-1, in signed Q2.(TW_WIDTH-2),
// computed at elaboration. Read is combinational.
// Ports:
//   i_addr  : twiddle index k
//   o_w_re  : Re(W^k)
//   o_w_im  : Im(W^k)
// ---------------------------------------------------------------------------
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int LOG2N    = 2,
    parameter int TW_WIDTH = 16
) (
    input  logic [((LOG2N > 1) ? LOG2N - 1 : 1)-1:0] i_addr,
    output logic signed [TW_WIDTH-1:0]               o_w_re,
    output logic signed [TW_WIDTH-1:0]               o_w_im
);

    localparam int AW    = (LOG2N > 1) ? LOG2N - 1 : 1;
    localparam int DEPTH = 1 << AW;

    logic signed [TW_WIDTH-1:0] w_tab_re [0:DEPTH-1];
    logic signed [TW_WIDTH-1:0] w_tab_im [0:DEPTH-1];

    // For N=2 the address is padded to one bit; the spare entry is never addressed.
    for (genvar g = 0; g < DEPTH; g++) begin : g_tw
        localparam logic signed [31:0] C_RE = tw_quant(g, LOG2N, TW_WIDTH, 1'b0);
        localparam logic signed [31:0] C_IM = tw_quant(g, LOG2N, TW_WIDTH, 1'b1);
        assign w_tab_re[g] = C_RE[TW_WIDTH-1:0];
        assign w_tab_im[g] = C_IM[TW_WIDTH-1:0];
    end

    assign o_w_re = w_tab_re[i_addr];
    assign o_w_im = w_tab_im[i_addr];

endmodule

// File: rtl/fft_radix2_stream.sv
// ---------------------------------------------------------------------------
// fft_radix2_stream
// Streaming in-place radix-2 DIT FFT, N = 2**LOG2N points, one butterfly per
// clock. A frame is loaded at bit-reversed addresses, transformed in
// LOG2N*N/2 cycles, then unloaded in natural order from registered outputs.
// Ports:
//   sys_clk_i          : clock, rising edge
//   rst_n_i            : asynchronous active-low reset
//   data_in_flag_i     : marks input word x[0]
//   xn_real_i/imag_i   : input sample (signed DATA_WIDTH)
//   ready_o            : high in IDLE, a new frame may start
//   data_out_flag_o    : marks output word X[0]
//   data_out_valid_o   : X[k] present on xk_*_o
//   xk_real_o/imag_o   : output bin (signed DATA_WIDTH+LOG2N), 0 when not valid
//   frame_drop_o       : one-cycle pulse for a start flag ignored in COMPUTE/UNLOAD
// ---------------------------------------------------------------------------
module fft_radix2_stream
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2N      = 2,
    parameter int TW_WIDTH   = 16
) (
    input  logic                               sys_clk_i,
    input  logic                               rst_n_i,
    input  logic                               data_in_flag_i,
    input  logic signed [DATA_WIDTH-1:0]       xn_real_i,
    input  logic signed [DATA_WIDTH-1:0]       xn_imag_i,
    output logic                               ready_o,
    output logic                               data_out_flag_o,
    output logic                               data_out_valid_o,
    output logic signed [DATA_WIDTH+LOG2N-1:0] xk_real_o,
    output logic signed [DATA_WIDTH+LOG2N-1:0] xk_imag_o,
    output logic                               frame_drop_o
);

    localparam int N  = 1 << LOG2N;
    localparam int IW = DATA_WIDTH + LOG2N;
    localparam int PW = IW + TW_WIDTH + 1;
    localparam int AW = (LOG2N > 1) ? LOG2N - 1 : 1;

    localparam logic [LOG2N-1:0] ONE        = LOG2N'(1);
    localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] LAST_BF    = LOG2N'(N / 2 - 1);
    localparam logic [2:0]       LAST_STAGE = 3'(LOG2N - 1);

    logic [1:0]             r_state;
    logic [LOG2N-1:0]       r_cnt;
    logic [LOG2N-1:0]       r_bf;
    logic [2:0]             r_stage;
    logic signed [IW-1:0]   r_xk_re;
    logic signed [IW-1:0]   r_xk_im;
    logic                   r_valid;
    logic                   r_oflag;
    logic                   r_drop;
    logic signed [IW-1:0]   r_mem_re [0:N-1];
    logic signed [IW-1:0]   r_mem_im [0:N-1];

    logic                       w_load_restart;
    logic [LOG2N-1:0]           w_ld_addr;
    logic [LOG2N-1:0]           w_mask;
    logic [LOG2N-1:0]           w_top;
    logic [LOG2N-1:0]           w_bot;
    logic [AW-1:0]              w_tw_addr;
    logic signed [TW_WIDTH-1:0] w_w_re;
    logic signed [TW_WIDTH-1:0] w_w_im;
    logic signed [IW-1:0]       w_a_re;
    logic signed [IW-1:0]       w_a_im;
    logic signed [IW-1:0]       w_b_re;
    logic signed [IW-1:0]       w_b_im;
    logic signed [PW-1:0]       w_prod_re;
    logic signed [PW-1:0]       w_prod_im;
    logic signed [IW-1:0]       w_t_re;
    logic signed [IW-1:0]       w_t_im;
    logic signed [IW-1:0]       w_a2_re;
    logic signed [IW-1:0]       w_a2_im;
    logic signed [IW-1:0]       w_b2_re;
    logic signed [IW-1:0]       w_b2_im;

    assign w_load_restart = data_in_flag_i && ((r_state == ST_IDLE) || (r_state == ST_LOAD));

    // Butterfly b of stage s pairs (top, top + 2^s): top inserts a zero bit at
    // position s into b, and the twiddle index is (b mod 2^s) * N / 2^(s+1).
    always_comb begin
        w_ld_addr = LOG2N'(bitrev(32'(r_cnt), LOG2N));
        w_mask    = LOG2N'((32'd1 << r_stage) - 32'd1);
        w_top     = ((r_bf & ~w_mask) << 1) | (r_bf & w_mask);
        w_bot     = w_top | LOG2N'(32'd1 << r_stage);
        w_tw_addr = AW'(32'(r_bf & w_mask) << (32'(LOG2N - 1) - 32'(r_stage)));
    end

    fft_twiddle_rom #(
        .LOG2N    (LOG2N),
        .TW_WIDTH (TW_WIDTH)
    ) u_twiddle_rom (
        .i_addr (w_tw_addr),
        .o_w_re (w_w_re),
        .o_w_im (w_w_im)
    );

    // Full-precision complex multiply W*B, truncated back to Q0 by an
    // arithmetic shift; W = 1 and W = -j therefore pass B through exactly.
    always_comb begin
        w_a_re    = r_mem_re[w_top];
        w_a_im    = r_mem_im[w_top];
        w_b_re    = r_mem_re[w_bot];
        w_b_im    = r_mem_im[w_bot];
        w_prod_re = PW'(w_b_re) * PW'(w_w_re) - PW'(w_b_im) * PW'(w_w_im);
        w_prod_im = PW'(w_b_re) * PW'(w_w_im) + PW'(w_b_im) * PW'(w_w_re);
        w_t_re    = IW'(w_prod_re >>> (TW_WIDTH - 2));
        w_t_im    = IW'(w_prod_im >>> (TW_WIDTH - 2));
        w_a2_re   = w_a_re + w_t_re;
        w_a2_im   = w_a_im + w_t_im;
        w_b2_re   = w_a_re - w_t_re;
        w_b2_im   = w_a_im - w_t_im;
    end

    // Sample memory: not reset; a reset only discards the frame via the FSM.
    always_ff @(posedge sys_clk_i) begin
        if (w_load_restart) begin
            r_mem_re[0] <= IW'(xn_real_i);
            r_mem_im[0] <= IW'(xn_imag_i);
        end else if (r_state == ST_LOAD) begin
            r_mem_re[w_ld_addr] <= IW'(xn_real_i);
            r_mem_im[w_ld_addr] <= IW'(xn_imag_i);
        end else if (r_state == ST_COMPUTE) begin
            r_mem_re[w_top] <= w_a2_re;
            r_mem_im[w_top] <= w_a2_im;
            r_mem_re[w_bot] <= w_b2_re;
            r_mem_im[w_bot] <= w_b2_im;
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bf    <= '0;
            r_stage <= '0;
            r_xk_re <= '0;
            r_xk_im <= '0;
            r_valid <= 1'b0;
            r_oflag <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_xk_re <= '0;
            r_xk_im <= '0;
            r_valid <= 1'b0;
            r_oflag <= 1'b0;
            r_drop  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (data_in_flag_i) begin
                        r_cnt   <= ONE;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (data_in_flag_i) begin
                        r_cnt <= ONE;
                    end else if (r_cnt == LAST_IDX) begin
                        r_bf    <= '0;
                        r_stage <= '0;
                        r_state <= ST_COMPUTE;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                ST_COMPUTE: begin
                    r_drop <= data_in_flag_i;
                    if (r_bf == LAST_BF) begin
                        r_bf <= '0;
                        if (r_stage == LAST_STAGE) begin
                            r_cnt   <= '0;
                            r_state <= ST_UNLOAD;
                        end else begin
                            r_stage <= r_stage + 3'd1;
                        end
                    end else begin
                        r_bf <= r_bf + ONE;
                    end
                end
                ST_UNLOAD: begin
                    r_drop  <= data_in_flag_i;
                    r_xk_re <= r_mem_re[r_cnt];
                    r_xk_im <= r_mem_im[r_cnt];
                    r_valid <= 1'b1;
                    r_oflag <= (r_cnt == '0);
                    r_cnt   <= r_cnt + ONE;
                    if (r_cnt == LAST_IDX) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready_o          = (r_state == ST_IDLE);
    assign data_out_flag_o  = r_oflag;
    assign data_out_valid_o = r_valid;
    assign xk_real_o        = r_xk_re;
    assign xk_imag_o        = r_xk_im;
    assign frame_drop_o     = r_drop;

endmodule

// File: tb/tb_fft_radix2_stream.sv
// ---------------------------------------------------------------------------
// tb_fft_radix2_stream
// Bench for fft_radix2_stream: an N=4 and an N=8 instance share the stimulus;
// each test resets, drives one selected instance and compares its output
// against a direct floating-point DFT of the same input.
// ---------------------------------------------------------------------------
module tb_fft_radix2_stream;

    localparam int DW = 16;
    localparam int TW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 flag;
    logic signed [DW-1:0] xr;
    logic signed [DW-1:0] xi;

    logic                 r4, f4, v4, d4;
    logic signed [DW+1:0] re4, im4;
    logic                 r8, f8, v8, d8;
    logic signed [DW+2:0] re8, im8;

    fft_radix2_stream #(.DATA_WIDTH(DW), .LOG2N(2), .TW_WIDTH(TW)) u_dut4 (
        .sys_clk_i        (clk),
        .rst_n_i          (rst_n),
        .data_in_flag_i   (flag),
        .xn_real_i        (xr),
        .xn_imag_i        (xi),
        .ready_o          (r4),
        .data_out_flag_o  (f4),
        .data_out_valid_o (v4),
        .xk_real_o        (re4),
        .xk_imag_o        (im4),
        .frame_drop_o     (d4)
    );

    fft_radix2_stream #(.DATA_WIDTH(DW), .LOG2N(3), .TW_WIDTH(TW)) u_dut8 (
        .sys_clk_i        (clk),
        .rst_n_i          (rst_n),
        .data_in_flag_i   (flag),
        .xn_real_i        (xr),
        .xn_imag_i        (xi),
        .ready_o          (r8),
        .data_out_flag_o  (f8),
        .data_out_valid_o (v8),
        .xk_real_o        (re8),
        .xk_imag_o        (im8),
        .frame_drop_o     (d8)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 4;

    logic o_ready, o_flag, o_valid, o_drop;
    int   o_re, o_im;

    always_comb begin
        if (sel == 8) begin
            o_ready = r8; o_flag = f8; o_valid = v8; o_drop = d8;
            o_re = int'(re8); o_im = int'(im8);
        end else begin
            o_ready = r4; o_flag = f4; o_valid = v4; o_drop = d4;
            o_re = int'(re4); o_im = int'(im4);
        end
    end

    int  in_re [8];
    int  in_im [8];
    int  got_re [8];
    int  got_im [8];
    real ex_re [8];
    real ex_im [8];

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int expv, input int tol);
        n_tests++;
        assert (((obs - expv) <= tol) && ((expv - obs) <= tol)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, expv, tol);
        end
    endtask

    // X[k] = sum x[m] * exp(-j*2*pi*k*m/n)
    task automatic model_dft(input int n);
        real a;
        for (int k = 0; k < n; k++) begin
            ex_re[k] = 0.0;
            ex_im[k] = 0.0;
            for (int m = 0; m < n; m++) begin
                a = 2.0 * 3.14159265358979323846 * real'(k * m) / real'(n);
                ex_re[k] += real'(in_re[m]) * $cos(a) + real'(in_im[m]) * $sin(a);
                ex_im[k] += real'(in_im[m]) * $cos(a) - real'(in_re[m]) * $sin(a);
            end
        end
    endtask

    task automatic gen_rand(input int n, input int amp);
        for (int i = 0; i < n; i++) begin
            in_re[i] = int'($urandom_range(0, 2 * amp - 1)) - amp;
            in_im[i] = int'($urandom_range(0, 2 * amp - 1)) - amp;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flag  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Caller sits at a negedge; word i is sampled at the i-th following posedge.
    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            flag = (i == 0);
            xr   = DW'(in_re[i]);
            xi   = DW'(in_im[i]);
            @(negedge clk);
        end
        flag = 1'b0;
        xr   = '0;
        xi   = '0;
    endtask

    task automatic collect(input int n, input int exp_lat, input bit tail, input string tag);
        int lat;
        lat = 0;
        while ((o_flag !== 1'b1) && (lat < 400)) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        if (o_flag !== 1'b1) return;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            got_re[k] = o_re;
            got_im[k] = o_im;
            chk($sformatf("%s.valid%0d", tag, k), int'(o_valid), 1);
            chk($sformatf("%s.oflag%0d", tag, k), int'(o_flag), (k == 0) ? 1 : 0);
        end
        if (tail) begin
            @(negedge clk);
            chk({tag, ".tail.valid"}, int'(o_valid), 0);
            chk({tag, ".tail.re"}, o_re, 0);
            chk({tag, ".tail.im"}, o_im, 0);
            chk({tag, ".tail.ready"}, int'(o_ready), 1);
        end
    endtask

    task automatic cmp_frame(input int n, input int tol, input string tag);
        for (int k = 0; k < n; k++) begin
            if (tol == 0) begin
                chk($sformatf("%s.X%0d.re", tag, k), got_re[k], rnd(ex_re[k]));
                chk($sformatf("%s.X%0d.im", tag, k), got_im[k], rnd(ex_im[k]));
            end else begin
                chk_tol($sformatf("%s.X%0d.re", tag, k), got_re[k], rnd(ex_re[k]), tol);
                chk_tol($sformatf("%s.X%0d.im", tag, k), got_im[k], rnd(ex_im[k]), tol);
            end
        end
    endtask

    // Frame end to X[0]: S butterfly cycles plus the output register.
    function automatic int lat_of(input int n);
        return ((n == 4) ? 2 * 4 / 2 : 3 * 8 / 2) + 1;
    endfunction

    task automatic run_frame(input int n, input int tol, input string tag);
        model_dft(n);
        drive(n);
        collect(n, lat_of(n), 1'b1, tag);
        cmp_frame(n, tol, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        flag  = 1'b0;
        xr    = '0;
        xi    = '0;
        for (int i = 0; i < 8; i++) begin
            in_re[i] = 0;
            in_im[i] = 0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        sel = 4;
        chk("rst.ready", int'(o_ready), 1);
        chk("rst.valid", int'(o_valid), 0);
        chk("rst.oflag", int'(o_flag), 0);
        chk("rst.drop", int'(o_drop), 0);
        chk("rst.re", o_re, 0);
        chk("rst.im", o_im, 0);
        sel = 8;
        chk("rst8.ready", int'(o_ready), 1);
        chk("rst8.valid", int'(o_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // N=4 directed frames
        sel = 4;
        do_reset();
        in_re[0] = 100; in_re[1] = 0; in_re[2] = 0; in_re[3] = 0;
        for (int i = 0; i < 4; i++) in_im[i] = 0;
        run_frame(4, 0, "impulse");
        for (int k = 0; k < 4; k++) chk($sformatf("impulse.const%0d", k), got_re[k], 100);

        do_reset();
        for (int i = 0; i < 4; i++) begin in_re[i] = 1; in_im[i] = 0; end
        run_frame(4, 0, "ones");

        do_reset();
        in_re[0] = 0; in_re[1] = 1; in_re[2] = 0; in_re[3] = -1;
        for (int i = 0; i < 4; i++) in_im[i] = 0;
        run_frame(4, 0, "alt");
        chk("alt.X1.im.const", got_im[1], -2);
        chk("alt.X3.im.const", got_im[3], 2);

        // N=4 random frames, full-scale inputs
        for (int t = 0; t < 3; t++) begin
            do_reset();
            gen_rand(4, 32768);
            run_frame(4, 0, $sformatf("rand4_%0d", t));
        end

        // Back-to-back: flag in the first IDLE cycle after X[N-1]
        do_reset();
        gen_rand(4, 32768);
        model_dft(4);
        drive(4);
        collect(4, lat_of(4), 1'b0, "b2b_a");
        cmp_frame(4, 0, "b2b_a");
        chk("b2b.ready", int'(o_ready), 1);
        gen_rand(4, 32768);
        run_frame(4, 0, "b2b_b");

        // Flag during LOAD restarts the load
        do_reset();
        gen_rand(4, 32768);
        drive(2);
        gen_rand(4, 32768);
        run_frame(4, 0, "restart");

        // Flag during COMPUTE is dropped, output unchanged
        do_reset();
        gen_rand(4, 32768);
        model_dft(4);
        drive(4);
        flag = 1'b1;
        @(negedge clk);
        chk("drop.pulse", int'(o_drop), 1);
        flag = 1'b0;
        @(negedge clk);
        chk("drop.clear", int'(o_drop), 0);
        collect(4, lat_of(4) - 2, 1'b1, "drop");
        cmp_frame(4, 0, "drop");

        // Reset during UNLOAD
        do_reset();
        gen_rand(4, 32768);
        drive(4);
        repeat (5) @(negedge clk);
        chk("rstmid.x0flag", int'(o_flag), 1);
        @(negedge clk);
        chk("rstmid.x1valid", int'(o_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.valid", int'(o_valid), 0);
        chk("rstmid.oflag", int'(o_flag), 0);
        chk("rstmid.re", o_re, 0);
        chk("rstmid.im", o_im, 0);
        chk("rstmid.ready", int'(o_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        gen_rand(4, 32768);
        run_frame(4, 0, "after_rst");

        // N=8 full-scale tone at bin 1
        sel = 8;
        do_reset();
        for (int m = 0; m < 8; m++) begin
            in_re[m] = rnd(32767.0 * $cos(2.0 * 3.14159265358979323846 * real'(m) / 8.0));
            in_im[m] = rnd(32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(m) / 8.0));
        end
        run_frame(8, 8, "tone");
        chk_tol("tone.peak.re", got_re[1], 8 * 32767, 8);
        chk_tol("tone.peak.im", got_im[1], 0, 8);
        for (int k = 0; k < 8; k++) begin
            if (k != 1) begin
                chk_tol($sformatf("tone.leak%0d.re", k), got_re[k], 0, 8);
                chk_tol($sformatf("tone.leak%0d.im", k), got_im[k], 0, 8);
            end
        end

        // N=8 random frames
        for (int t = 0; t < 2; t++) begin
            do_reset();
            gen_rand(8, 8192);
            run_frame(8, 8, $sformatf("rand8_%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
